// File: rtl/cobra_boot_ctrl.sv
// cobra_boot_ctrl: byte-stream image loader and run/step controller for CYBERcobra (optional COBRA_BOOT_CHECKSUM_EN)
module cobra_boot_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  output logic              rx_ready_o,
  input  logic              load_req_i,
  input  logic              start_i,
  input  logic              run_i,
  input  logic              step_i,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              core_rst_o,
  output logic              core_en_o,
  output logic [2:0]        state_o,
  output logic              err_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, LEN = 3'd1, LOAD = 3'd2, CSUM = 3'd3, RUN = 3'd4, ERR = 3'd5} state_t;
`ifdef COBRA_BOOT_CHECKSUM_EN
  localparam state_t DONE = CSUM;
`else
  localparam state_t DONE = RUN;
`endif
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;
  state_t state_q, state_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [15:0] len_q, len_d, wcnt_q, wcnt_d, n;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [23:0] asm_q, asm_d;
  logic [31:0] wdata_q, wdata_d;
  logic we_q, we_d, s1_q, s2_q, pulse_q;
  logic acc, lenb, last, wdone;
`ifdef COBRA_BOOT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  assign acc = rx_valid_i & rx_ready_o;
  assign n = {rx_data_i, len_q[7:0]};
  assign lenb = acc && state_q == LEN && bcnt_q[0];
  assign wdone = acc && state_q == LOAD && bcnt_q == 2'd3 && !load_req_i;
  assign last = wdone && wcnt_q + 16'd1 == len_q;
  assign imem_we_o = we_q;
  assign imem_addr_o = addr_q;
  assign imem_wdata_o = wdata_q;
  // state register
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state_q <= IDLE;
    else state_q <= state_d;
  // next state: a load request overrides every other transition
  always_comb begin
    state_d = load_req_i ? LEN :
              (state_q == IDLE && start_i) ? RUN :
              lenb ? ({1'b0, n} > CAP ? ERR : n == 16'd0 ? DONE : LOAD) :
              last ? DONE :
`ifdef COBRA_BOOT_CHECKSUM_EN
              (acc && state_q == CSUM) ? (rx_data_i == csum_q ? RUN : ERR) :
`endif
              state_q;
  end
  // outputs decoded from the current state
  always_comb begin
    rx_ready_o = state_q inside {LEN, LOAD, CSUM};
    core_rst_o = state_q != RUN;
    core_en_o = state_q == RUN && (run_i || pulse_q);
    err_o = state_q == ERR;
    state_o = state_q;
  end
  // datapath next values: counters clear on a load request, address advances the cycle after a write
  always_comb begin
    bcnt_d = (load_req_i || lenb) ? 2'd0 : acc ? bcnt_q + 2'd1 : bcnt_q;
    len_d = load_req_i ? 16'd0 : (acc && state_q == LEN) ? (bcnt_q[0] ? n : {8'h00, rx_data_i}) : len_q;
    asm_d = acc ? {rx_data_i, asm_q[23:8]} : asm_q;
    wdata_d = wdone ? {rx_data_i, asm_q} : wdata_q;
    we_d = wdone;
    wcnt_d = load_req_i ? 16'd0 : wdone ? wcnt_q + 16'd1 : wcnt_q;
    addr_d = load_req_i ? '0 : (we_q && wcnt_q < len_q) ? wcnt_q[ADDR_W-1:0] : addr_q;
`ifdef COBRA_BOOT_CHECKSUM_EN
    csum_d = load_req_i ? 8'h00 : (acc && state_q == LOAD) ? csum_q ^ rx_data_i : csum_q;
`endif
  end
  // datapath registers and step synchronizer / edge detector
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      bcnt_q <= '0;
      len_q <= '0;
      asm_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      wcnt_q <= '0;
      addr_q <= '0;
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      pulse_q <= 1'b0;
`ifdef COBRA_BOOT_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      bcnt_q <= bcnt_d;
      len_q <= len_d;
      asm_q <= asm_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      wcnt_q <= wcnt_d;
      addr_q <= addr_d;
      s1_q <= step_i;
      s2_q <= s1_q;
      pulse_q <= s1_q & ~s2_q & ~run_i;
`ifdef COBRA_BOOT_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
endmodule
